// File: rtl/gpu_pkg.sv
// Shared GPU types: program-memory controller FSM states.
package gpu_pkg;

   typedef enum logic [0:0] {
      PMC_IDLE  = 1'b0,
      PMC_ISSUE = 1'b1
   } pmc_state_t;

endpackage

// File: rtl/pmc_rr_arbiter.sv
// Combinational round-robin grant: first eligible channel after last_ptr wins.
module pmc_rr_arbiter #(
   parameter int NUM_CHANNELS = 4,
   parameter int IDX_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic [NUM_CHANNELS-1:0] eligible,
   input  logic [IDX_W-1:0]        last_ptr,
   output logic                    grant_valid,
   output logic [IDX_W-1:0]        grant_index
);

   int idx;

   // Walk from the farthest offset to the nearest so the nearest eligible channel overwrites.
   always_comb begin
      grant_valid = 1'b0;
      grant_index = '0;
      idx         = 0;
      for (int i = NUM_CHANNELS; i >= 1; i--) begin
         idx = (int'(last_ptr) + i) % NUM_CHANNELS;
         if (eligible[IDX_W'(idx)]) begin
            grant_valid = 1'b1;
            grant_index = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/prog_mem_controller.sv
// Round-robin program-memory responder for NUM_CHANNELS instruction fetchers.
// Optional address range check enabled by defining PMC_RANGE_CHECK_EN.
module prog_mem_controller
   import gpu_pkg::*;
#(
   parameter int NUM_CHANNELS = 4,
   parameter int ADDR_WIDTH   = 8,
   parameter int INSTR_WIDTH  = 16,
   parameter int PROG_DEPTH   = 256
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [NUM_CHANNELS-1:0]                  consumer_read_valid,
   input  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]  consumer_read_addr,
   output logic [NUM_CHANNELS-1:0]                  consumer_read_ready,
   output logic [NUM_CHANNELS-1:0][INSTR_WIDTH-1:0] consumer_read_data,
   output logic                                     mem_read_valid,
   output logic [ADDR_WIDTH-1:0]                    mem_read_addr,
   input  logic                                     mem_read_ready,
   input  logic [INSTR_WIDTH-1:0]                   mem_read_data,
   output logic                                     busy,
   output logic                                     range_error
);

   localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_CHANNELS - 1);
`ifdef PMC_RANGE_CHECK_EN
   localparam bit RANGE_EN = 1'b1;
`else
   localparam bit RANGE_EN = 1'b0;
`endif

   pmc_state_t                             state_q, state_d;
   logic [IDX_W-1:0]                       last_q, last_d, ch_q, ch_d;
   logic [NUM_CHANNELS-1:0]                served_q, served_d, eligible, ready_d;
   logic [NUM_CHANNELS-1:0][INSTR_WIDTH-1:0] data_d;
   logic                                   mem_valid_d, range_err_q, range_err_d;
   logic [ADDR_WIDTH-1:0]                  mem_addr_d, grant_addr;
   logic                                   grant_valid;
   logic [IDX_W-1:0]                       grant_index;

   // A channel still holding valid the cycle after its ready must not be granted again.
   assign eligible    = consumer_read_valid & ~served_q;
   assign grant_addr  = consumer_read_addr[grant_index];
   assign busy        = (state_q != PMC_IDLE);
   assign range_error = range_err_q;

   pmc_rr_arbiter #(
      .NUM_CHANNELS (NUM_CHANNELS),
      .IDX_W        (IDX_W)
   ) u_arb (
      .eligible     (eligible),
      .last_ptr     (last_q),
      .grant_valid  (grant_valid),
      .grant_index  (grant_index)
   );

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      ch_d        = ch_q;
      served_d    = served_q & consumer_read_valid;
      ready_d     = '0;
      data_d      = consumer_read_data;
      mem_valid_d = mem_read_valid;
      mem_addr_d  = mem_read_addr;
      range_err_d = range_err_q;
      case (state_q)
         PMC_IDLE: begin
            if (grant_valid) begin
               ch_d = grant_index;
               // Out-of-range fetches are answered locally with a NOP, never reaching memory.
               if (RANGE_EN && (int'(grant_addr) >= PROG_DEPTH)) begin
                  ready_d[grant_index]  = 1'b1;
                  data_d[grant_index]   = '0;
                  served_d[grant_index] = 1'b1;
                  last_d                = grant_index;
                  range_err_d           = 1'b1;
               end else begin
                  mem_valid_d = 1'b1;
                  mem_addr_d  = grant_addr;
                  state_d     = PMC_ISSUE;
               end
            end
         end
         PMC_ISSUE: begin
            if (mem_read_ready) begin
               mem_valid_d      = 1'b0;
               ready_d[ch_q]    = 1'b1;
               data_d[ch_q]     = mem_read_data;
               served_d[ch_q]   = 1'b1;
               last_d           = ch_q;
               state_d          = PMC_IDLE;
            end
         end
         default: state_d = PMC_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q             <= PMC_IDLE;
         last_q              <= LAST_RST;
         ch_q                <= '0;
         served_q            <= '0;
         consumer_read_ready <= '0;
         consumer_read_data  <= '0;
         mem_read_valid      <= 1'b0;
         mem_read_addr       <= '0;
         range_err_q         <= 1'b0;
      end else begin
         state_q             <= state_d;
         last_q              <= last_d;
         ch_q                <= ch_d;
         served_q            <= served_d;
         consumer_read_ready <= ready_d;
         consumer_read_data  <= data_d;
         mem_read_valid      <= mem_valid_d;
         mem_read_addr       <= mem_addr_d;
         range_err_q         <= range_err_d;
      end
   end

endmodule

// File: tb/tb_prog_mem_controller.sv
// Directed testbench for prog_mem_controller (4 channels, PROG_DEPTH=200).
module tb_prog_mem_controller;

   localparam int NC = 4;
   localparam int AW = 8;
   localparam int IW = 16;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [NC-1:0]           consumer_read_valid;
   logic [NC-1:0][AW-1:0]   consumer_read_addr;
   logic [NC-1:0]           consumer_read_ready;
   logic [NC-1:0][IW-1:0]   consumer_read_data;
   logic                    mem_read_valid;
   logic [AW-1:0]           mem_read_addr;
   logic                    mem_read_ready;
   logic [IW-1:0]           mem_read_data;
   logic                    busy;
   logic                    range_error;

   int checks   = 0;
   int failures = 0;

   prog_mem_controller #(
      .NUM_CHANNELS (NC),
      .ADDR_WIDTH   (AW),
      .INSTR_WIDTH  (IW),
      .PROG_DEPTH   (200)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .consumer_read_valid (consumer_read_valid),
      .consumer_read_addr  (consumer_read_addr),
      .consumer_read_ready (consumer_read_ready),
      .consumer_read_data  (consumer_read_data),
      .mem_read_valid      (mem_read_valid),
      .mem_read_addr       (mem_read_addr),
      .mem_read_ready      (mem_read_ready),
      .mem_read_data       (mem_read_data),
      .busy                (busy),
      .range_error         (range_error)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset               = 1'b1;
      consumer_read_valid = '0;
      consumer_read_addr  = '0;
      mem_read_ready      = 1'b0;
      mem_read_data       = '0;
      tick();
      tick();
      chk("rst_mem_valid", 64'(mem_read_valid), 64'd0);
      chk("rst_mem_addr",  64'(mem_read_addr),  64'd0);
      chk("rst_busy",      64'(busy),           64'd0);
      chk("rst_ready",     64'(consumer_read_ready), 64'd0);
      chk("rst_data",      64'(consumer_read_data),  64'd0);
      chk("rst_range",     64'(range_error),    64'd0);
      reset = 1'b0;
      tick();

      // Single request, memory answers three cycles after mem_read_valid rises
      consumer_read_valid[1] = 1'b1;
      consumer_read_addr[1]  = 8'h05;
      tick();
      chk("single_mem_valid", 64'(mem_read_valid), 64'd1);
      chk("single_mem_addr",  64'(mem_read_addr),  64'h05);
      chk("single_busy",      64'(busy),           64'd1);
      tick();
      chk("single_wait_valid", 64'(mem_read_valid), 64'd1);
      chk("single_wait_ready", 64'(consumer_read_ready), 64'd0);
      tick();
      mem_read_ready = 1'b1;
      mem_read_data  = 16'hABCD;
      tick();
      mem_read_ready = 1'b0;
      chk("single_ready",     64'(consumer_read_ready), 64'b0010);
      chk("single_data",      64'(consumer_read_data[1]), 64'hABCD);
      chk("single_mem_drop",  64'(mem_read_valid), 64'd0);
      chk("single_idle",      64'(busy), 64'd0);
      tick();
      chk("single_pulse_end", 64'(consumer_read_ready), 64'd0);
      chk("single_no_regrant", 64'(mem_read_valid), 64'd0);
      chk("single_data_held", 64'(consumer_read_data[1]), 64'hABCD);
      consumer_read_valid[1] = 1'b0;
      tick();
      chk("single_still_idle", 64'(mem_read_valid), 64'd0);
      tick();

      // Contention after a fresh reset: order 0,1,2,3 with zero-wait memory
      reset = 1'b1;
      tick();
      reset = 1'b0;
      consumer_read_valid = 4'b1111;
      for (int i = 0; i < NC; i++) consumer_read_addr[i] = 8'(8'h20 + i);
      mem_read_ready = 1'b1;
      mem_read_data  = 16'h0;
      for (int i = 0; i < NC; i++) begin
         tick();
         chk($sformatf("cont_grant_valid%0d", i), 64'(mem_read_valid), 64'd1);
         chk($sformatf("cont_grant_addr%0d", i),  64'(mem_read_addr), 64'(8'h20 + i));
         chk($sformatf("cont_no_ready%0d", i),    64'(consumer_read_ready), 64'd0);
         mem_read_data = 16'(16'h1000 + i);
         tick();
         chk($sformatf("cont_ready%0d", i), 64'(consumer_read_ready), 64'(4'b0001 << i));
         chk($sformatf("cont_data%0d", i),  64'(consumer_read_data[i]), 64'(16'h1000 + i));
      end
      tick();
      chk("cont_all_served", 64'(mem_read_valid), 64'd0);
      consumer_read_valid = '0;
      tick();
      tick();

      // Fairness: ch0 re-requests during ch1's transaction, ch2 must go first
      consumer_read_valid   = 4'b0111;
      consumer_read_addr[0] = 8'h30;
      consumer_read_addr[1] = 8'h31;
      consumer_read_addr[2] = 8'h32;
      tick();
      chk("fair_g0_addr", 64'(mem_read_addr), 64'h30);
      mem_read_data = 16'hC000;
      tick();
      chk("fair_r0", 64'(consumer_read_ready), 64'b0001);
      consumer_read_valid[0] = 1'b0;
      tick();
      chk("fair_g1_addr", 64'(mem_read_addr), 64'h31);
      consumer_read_valid[0] = 1'b1;
      consumer_read_addr[0]  = 8'h34;
      mem_read_data = 16'hC001;
      tick();
      chk("fair_r1", 64'(consumer_read_ready), 64'b0010);
      chk("fair_d1", 64'(consumer_read_data[1]), 64'hC001);
      consumer_read_valid[1] = 1'b0;
      tick();
      chk("fair_g2_before_ch0", 64'(mem_read_addr), 64'h32);
      mem_read_data = 16'hC002;
      tick();
      chk("fair_r2", 64'(consumer_read_ready), 64'b0100);
      consumer_read_valid[2] = 1'b0;
      tick();
      chk("fair_g0b_addr", 64'(mem_read_addr), 64'h34);
      mem_read_data = 16'hC004;
      tick();
      chk("fair_r0b", 64'(consumer_read_ready), 64'b0001);
      chk("fair_d0b", 64'(consumer_read_data[0]), 64'hC004);
      consumer_read_valid[0] = 1'b0;
      mem_read_ready = 1'b0;
      tick();
      tick();

      // Idle noise on mem_read_ready
      mem_read_ready = 1'b1;
      mem_read_data  = 16'hDEAD;
      tick();
      mem_read_ready = 1'b0;
      chk("noise_ready", 64'(consumer_read_ready), 64'd0);
      chk("noise_busy",  64'(busy), 64'd0);
      chk("noise_data",  64'(consumer_read_data[0]), 64'hC004);
      tick();

      // Reset during ISSUE, then a clean transaction to 0x10
      consumer_read_valid[3] = 1'b1;
      consumer_read_addr[3]  = 8'h40;
      tick();
      chk("rmid_issue", 64'(mem_read_valid), 64'd1);
      reset = 1'b1;
      tick();
      chk("rmid_mem_valid", 64'(mem_read_valid), 64'd0);
      chk("rmid_mem_addr",  64'(mem_read_addr),  64'd0);
      chk("rmid_busy",      64'(busy), 64'd0);
      chk("rmid_data",      64'(consumer_read_data), 64'd0);
      reset = 1'b0;
      consumer_read_valid[3] = 1'b0;
      tick();
      consumer_read_valid[0] = 1'b1;
      consumer_read_addr[0]  = 8'h10;
      tick();
      chk("rmid_new_addr", 64'(mem_read_addr), 64'h10);
      mem_read_ready = 1'b1;
      mem_read_data  = 16'h1234;
      tick();
      chk("rmid_new_ready", 64'(consumer_read_ready), 64'b0001);
      chk("rmid_new_data",  64'(consumer_read_data[0]), 64'h1234);
      mem_read_ready = 1'b0;
      consumer_read_valid[0] = 1'b0;
      tick();
      tick();

      // Address 0xF0 against PROG_DEPTH=200
      consumer_read_valid[0] = 1'b1;
      consumer_read_addr[0]  = 8'hF0;
      tick();
`ifdef PMC_RANGE_CHECK_EN
      chk("range_no_mem",  64'(mem_read_valid), 64'd0);
      chk("range_busy",    64'(busy), 64'd0);
      chk("range_ready",   64'(consumer_read_ready), 64'b0001);
      chk("range_nop",     64'(consumer_read_data[0]), 64'h0000);
      chk("range_err_set", 64'(range_error), 64'd1);
      consumer_read_valid[0] = 1'b0;
      tick();
      chk("range_pulse_end", 64'(consumer_read_ready), 64'd0);
      tick();
      chk("range_err_sticky", 64'(range_error), 64'd1);
`else
      chk("range_mem_valid", 64'(mem_read_valid), 64'd1);
      chk("range_mem_addr",  64'(mem_read_addr), 64'hF0);
      mem_read_ready = 1'b1;
      mem_read_data  = 16'h5555;
      tick();
      chk("range_ready", 64'(consumer_read_ready), 64'b0001);
      chk("range_data",  64'(consumer_read_data[0]), 64'h5555);
      chk("range_err_zero", 64'(range_error), 64'd0);
      mem_read_ready = 1'b0;
      consumer_read_valid[0] = 1'b0;
      tick();
      chk("range_err_still_zero", 64'(range_error), 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prog_mem_controller.md
# prog_mem_controller

Program-memory responder serving the per-core instruction fetchers. Accepts valid/ready read requests from NUM_CHANNELS fetcher channels, arbitrates them round-robin onto a single external program-memory read port, and returns each fetched instruction to the requesting channel as a one-cycle ready pulse with data. It sits between the cores' fetchers and the program memory, one instance per GPU.

## Interface
- NUM_CHANNELS, 4: number of fetcher channels, ≥1
- ADDR_WIDTH, 8: program address width
- INSTR_WIDTH, 16: instruction width
- PROG_DEPTH, 256: valid program words; used only with PMC_RANGE_CHECK_EN

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- consumer_read_valid  in  [NUM_CHANNELS]  per-channel read request; held high until ready seen
- consumer_read_addr  in  [NUM_CHANNELS][ADDR_WIDTH]  per-channel address; stable while valid
- consumer_read_ready  out  [NUM_CHANNELS]  one-cycle response pulse
- consumer_read_data  out  [NUM_CHANNELS][INSTR_WIDTH]  response data; valid with ready and held afterward
- mem_read_valid  out  1  request to program memory
- mem_read_addr  out  ADDR_WIDTH  address to program memory
- mem_read_ready  in  1  memory response strobe, data valid same cycle
- mem_read_data  in  INSTR_WIDTH  memory read data
- busy  out  1  high when state is not IDLE
- range_error  out  1  sticky out-of-range flag; constant 0 without macro

## Operation
- States: IDLE, ISSUE.
- Per-channel served flag. Set when that channel's ready pulses. Cleared on any cycle its valid is low. Eligible means valid && !served. This prevents re-serving a request whose valid is still high in the cycle after ready.
- IDLE: if any channel is eligible, grant one round-robin, starting after the last granted channel. Latch the channel index and address, set mem_read_valid=1 and mem_read_addr=addr, go to ISSUE.
- ISSUE: hold mem_read_valid/addr. On mem_read_ready:
  - mem_read_valid<=0
  - consumer_read_ready[ch]<=1 and consumer_read_data[ch]<=mem_read_data
  - served[ch]<=1, update round-robin pointer, go to IDLE
- consumer_read_ready is forced to 0 on every cycle it was not set in the previous cycle. The pulse is exactly one cycle.
- A channel dropping valid during ISSUE does not abort the memory transaction. The response still pulses and the channel ignores it.
- Only one transaction is outstanding at any time.
- Reset values:
  - all consumer_read_ready = 0, all consumer_read_data = 0
  - mem_read_valid = 0, mem_read_addr = 0
  - busy = 0, range_error = 0
  - served flags cleared, state IDLE
  - round-robin pointer = NUM_CHANNELS-1, so channel 0 wins first
- Reset mid-ISSUE abandons the transaction. The memory tolerates valid dropping without ready.

## Timing
- Request sampled eligible at cycle t: mem_read_valid high from t+1.
- mem_read_ready at cycle k: consumer_read_ready high at k+1 only. mem_read_valid low at k+1.
- Minimum latency (memory ready in the first ISSUE cycle): request at t, response at t+2.
- Back-to-back: the IDLE cycle at k+1 may grant another channel, so mem_read_valid rises again at k+2. Throughput is one transaction per 2 cycles minimum.
- Simultaneous requests: served in round-robin order. With 4 channels all requesting, grants are 0,1,2,3,0,…
- mem_read_ready while IDLE is ignored.

## Configuration
- PMC_RANGE_CHECK_EN defined:
  - A granted address ≥ PROG_DEPTH issues no memory request. State stays IDLE.
  - consumer_read_ready[ch] pulses at t+1 with data all-zero (NOP). served and the round-robin pointer update normally.
  - range_error sets and stays set until reset.
- Macro undefined: all addresses pass to memory, and range_error is tied 0.

## Structure
- gpu_pkg: pmc_state_t enum {PMC_IDLE, PMC_ISSUE}.
- Sub-module pmc_rr_arbiter: combinational round-robin grant.
  - Inputs: eligible vector, last pointer.
  - Outputs: grant_valid, grant_index.
  - Parameterised by NUM_CHANNELS.
- Datapath and FSM live in prog_mem_controller.

## Test plan
- Single request: ch1 valid, addr 0x05, memory ready 3 cycles after mem_read_valid, data 0xABCD → mem_read_addr=0x05; ch1 ready pulses exactly one cycle with 0xABCD; no second memory request while ch1 valid lingers one cycle.
- Contention: ch0–ch3 valid together, zero-wait memory → grant order 0,1,2,3. Responses at cycles 2,4,6,8 relative to the first sample.
- Fairness: ch0 re-requests immediately after each response while ch2 is pending → ch2 served before ch0's second request.
- Reset mid-ISSUE: reset asserted while mem_read_valid=1 → next cycle all outputs 0 and state IDLE; after release a new request to 0x10 completes normally.
- Range check (PMC_RANGE_CHECK_EN, PROG_DEPTH=200): ch0 addr 0xF0 → no mem_read_valid; ch0 ready at t+1 with 0x0000; range_error=1 and sticky. Undefined: same stimulus reaches memory and range_error stays 0.
- Idle noise: mem_read_ready pulsed with no request pending → no consumer_read_ready and no state change.
